// File: rtl/reset_sequencer.sv
// Staged reset sequencer: hold, wait for clock lock, release reset stages in order, run.
// Define RESET_SEQ_LOCK_FILTER_EN to require LOCK_FILTER consecutive lock samples before release.
module reset_sequencer #(
  parameter int NUM_STAGES   = 3,
  parameter int HOLD_CYCLES  = 16,
  parameter int STAGE_DELAY  = 8,
  parameter int LOCK_TIMEOUT = 1000,
  parameter int LOCK_FILTER  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  soft_rst_req,
  input  logic                  pll_locked,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  done,
  output logic                  timeout_err,
  output logic [3:0]            retry_cnt,
  output logic [1:0]            state_dbg
);

  // Handshake note: soft_rst_req is a level sampled every cycle; there is no ready/ack.

  localparam int REL_CYCLES = STAGE_DELAY * NUM_STAGES;
  localparam int MAX_A      = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CNT    = (MAX_A > REL_CYCLES) ? MAX_A : REL_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(REL_CYCLES - 1);

  if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_stages
    $error("reset_sequencer: NUM_STAGES out of range");
  end
  if (LOCK_FILTER < 1 || LOCK_FILTER > 255) begin : g_bad_filter
    $error("reset_sequencer: LOCK_FILTER out of range");
  end

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]   rst_out_q, rst_out_d;
  logic                    done_q, done_d;
  logic                    terr_q, terr_d;
  logic [3:0]              retry_q, retry_d;
  logic                    lock_ok;
  logic                    timeout;
  logic                    trigger;

`ifdef RESET_SEQ_LOCK_FILTER_EN
  localparam logic [7:0] FILT_LAST = 8'(LOCK_FILTER - 1);
  logic [7:0] filt_q, filt_d;
  assign lock_ok = pll_locked && (filt_q == FILT_LAST);
`else
  assign lock_ok = pll_locked;
`endif

  assign timeout = (state_q == WAIT_LOCK) && !lock_ok && (cnt_q == WAIT_LAST);
  // Loss of lock is a trigger only once release has started, and is never filtered.
  assign trigger = soft_rst_req ||
                   (!pll_locked && (state_q == RELEASE || state_q == RUN));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_out_d = rst_out_q;
    done_d    = done_q;
    terr_d    = terr_q;
    retry_d   = retry_q;
`ifdef RESET_SEQ_LOCK_FILTER_EN
    filt_d    = '0;
`endif
    case (state_q)
      HOLD: begin
        rst_out_d = '1;
        done_d    = 1'b0;
        if (soft_rst_req) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        rst_out_d = '1;
        done_d    = 1'b0;
        if (timeout) begin
          terr_d  = 1'b1;
          retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 1'b1;
        end
        if (soft_rst_req || timeout) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (lock_ok) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
`ifdef RESET_SEQ_LOCK_FILTER_EN
          filt_d = pll_locked ? filt_q + 1'b1 : '0;
`endif
        end
      end
      RELEASE: begin
        if (trigger) begin
          state_d   = HOLD;
          cnt_d     = '0;
          rst_out_d = '1;
          done_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (cnt_q == CNT_W'(STAGE_DELAY * (i + 1) - 1)) rst_out_d[i] = 1'b0;
          end
          if (cnt_q == REL_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (trigger) begin
          state_d   = HOLD;
          cnt_d     = '0;
          rst_out_d = '1;
          done_d    = 1'b0;
        end else begin
          rst_out_d = '0;
          done_d    = 1'b1;
        end
      end
      default: begin
        state_d   = HOLD;
        cnt_d     = '0;
        rst_out_d = '1;
        done_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      rst_out_q <= '1;
      done_q    <= 1'b0;
      terr_q    <= 1'b0;
      retry_q   <= '0;
`ifdef RESET_SEQ_LOCK_FILTER_EN
      filt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
      terr_q    <= terr_d;
      retry_q   <= retry_d;
`ifdef RESET_SEQ_LOCK_FILTER_EN
      filt_q    <= filt_d;
`endif
    end
  end

  assign rst_out     = rst_out_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign retry_cnt   = retry_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters; expected values are hand-derived.
module tb_reset_sequencer;

  localparam logic [31:0] S_HOLD = 0, S_WAIT = 1, S_REL = 2, S_RUN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       soft_rst_req = 1'b0;
  logic       pll_locked = 1'b1;
  logic [2:0] rst_out;
  logic       done;
  logic       timeout_err;
  logic [3:0] retry_cnt;
  logic [1:0] state_dbg;

  int errors = 0;
  int checks = 0;

  reset_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .soft_rst_req (soft_rst_req),
    .pll_locked   (pll_locked),
    .rst_out      (rst_out),
    .done         (done),
    .timeout_err  (timeout_err),
    .retry_cnt    (retry_cnt),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit so outputs are sampled off the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] st, input logic [31:0] ro,
                         input logic [31:0] dn);
    chk({tag, ".state"}, 32'(state_dbg), st);
    chk({tag, ".rst_out"}, 32'(rst_out), ro);
    chk({tag, ".done"}, 32'(done), dn);
  endtask

  initial begin
    // Reset values
    step(3);
    chk_all("reset", S_HOLD, 7, 0);
    chk("reset.terr", 32'(timeout_err), 0);
    chk("reset.retry", 32'(retry_cnt), 0);

    // Normal bring-up with lock held high
    rst = 1'b0;
    step(15);
    chk_all("hold15", S_HOLD, 7, 0);
    step(1);
    chk_all("wait16", S_WAIT, 7, 0);
    step(1);
    chk_all("rel_entry", S_REL, 7, 0);
    step(7);
    chk_all("rel7", S_REL, 7, 0);
    step(1);
    chk_all("rel8", S_REL, 6, 0);
    step(7);
    chk("rel15", 32'(rst_out), 6);
    step(1);
    chk("rel16", 32'(rst_out), 4);
    step(7);
    chk_all("rel23", S_REL, 4, 0);
    step(1);
    chk_all("rel24", S_RUN, 0, 1);
    step(5);
    chk_all("run_stay", S_RUN, 0, 1);

    // Single-cycle loss of lock in RUN
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    chk_all("lol", S_HOLD, 7, 0);
    step(16);
    chk("lol.wait", 32'(state_dbg), S_WAIT);
    step(25);
    chk_all("lol.run", S_RUN, 0, 1);

    // Soft reset 4 cycles into RELEASE; HOLD then lasts 16 cycles
    soft_rst_req = 1'b1;
    step(1);
    soft_rst_req = 1'b0;
    chk_all("soft_run", S_HOLD, 7, 0);
    step(17);
    chk("soft.rel", 32'(state_dbg), S_REL);
    step(4);
    soft_rst_req = 1'b1;
    step(1);
    soft_rst_req = 1'b0;
    chk_all("soft_rel", S_HOLD, 7, 0);
    step(15);
    chk("soft_rel.h15", 32'(state_dbg), S_HOLD);
    step(1);
    chk("soft_rel.h16", 32'(state_dbg), S_WAIT);

    // Soft reset in WAIT_LOCK, then in HOLD restarts the hold count
    soft_rst_req = 1'b1;
    step(1);
    soft_rst_req = 1'b0;
    chk("soft_wait", 32'(state_dbg), S_HOLD);
    step(10);
    soft_rst_req = 1'b1;
    step(1);
    soft_rst_req = 1'b0;
    step(15);
    chk("soft_hold.h15", 32'(state_dbg), S_HOLD);
    pll_locked = 1'b0;
    step(1);
    chk("soft_hold.h16", 32'(state_dbg), S_WAIT);

    // Lock timeout, then saturation of retry_cnt
    step(999);
    chk("to.999", 32'(state_dbg), S_WAIT);
    chk("to.999.terr", 32'(timeout_err), 0);
    step(1);
    chk_all("to.1000", S_HOLD, 7, 0);
    chk("to.terr", 32'(timeout_err), 1);
    chk("to.retry", 32'(retry_cnt), 1);
    for (int i = 2; i <= 17; i++) begin
      step(1016);
      chk("to.loop_retry", 32'(retry_cnt), (i > 15) ? 15 : i);
    end
    chk("to.sat_terr", 32'(timeout_err), 1);

    // rst mid-RELEASE clears sticky status
    pll_locked = 1'b1;
    step(17);
    chk("rst_mid.rel", 32'(state_dbg), S_REL);
    step(10);
    chk("rst_mid.ro", 32'(rst_out), 6);
    rst = 1'b1;
    step(1);
    chk_all("rst_mid", S_HOLD, 7, 0);
    chk("rst_mid.terr", 32'(timeout_err), 0);
    chk("rst_mid.retry", 32'(retry_cnt), 0);
    rst = 1'b0;

    // Soft reset coinciding with a timeout still records the timeout
    pll_locked = 1'b0;
    step(16);
    chk("coinc.wait", 32'(state_dbg), S_WAIT);
    step(999);
    soft_rst_req = 1'b1;
    step(1);
    soft_rst_req = 1'b0;
    chk("coinc.state", 32'(state_dbg), S_HOLD);
    chk("coinc.terr", 32'(timeout_err), 1);
    chk("coinc.retry", 32'(retry_cnt), 1);

    // Lock qualification in WAIT_LOCK
    step(16);
    chk("qual.wait", 32'(state_dbg), S_WAIT);
`ifdef RESET_SEQ_LOCK_FILTER_EN
    begin
      logic [7:0] pat;
      pat = 8'b1111_0111;
      for (int i = 0; i < 8; i++) begin
        pll_locked = pat[i];
        step(1);
        chk("filt", 32'(state_dbg), (i == 7) ? S_REL : S_WAIT);
      end
    end
`else
    pll_locked = 1'b0;
    step(1);
    chk("nofilt.low", 32'(state_dbg), S_WAIT);
    pll_locked = 1'b1;
    step(1);
    chk("nofilt.high", 32'(state_dbg), S_REL);
`endif
    step(24);
    chk_all("qual.run", S_RUN, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter: NUM_STAGES, 3, number of staged reset outputs (range 1..8).
REQ-002 Parameter: HOLD_CYCLES, 16, minimum cycles all outputs stay asserted after any reset trigger (range 1..65535).
REQ-003 Parameter: STAGE_DELAY, 8, cycles between successive stage releases (range 1..65535).
REQ-004 Parameter: LOCK_TIMEOUT, 1000, maximum cycles to wait for lock before retry (range 1..2^20-1).
REQ-005 Parameter: LOCK_FILTER, 4, consecutive high samples required to qualify lock when the filter is compiled in (range 1..255).
REQ-006 Port: clk input 1 sole clock; every register updates on its rising edge.
REQ-007 Port: rst input 1 reset; synchronous and active-high.
REQ-008 Port: soft_rst_req input 1 single-cycle request to re-run the full sequence.
REQ-009 Port: pll_locked input 1 clock-source lock indication, synchronous to clk.
REQ-010 Port: rst_out output NUM_STAGES active-high staged resets; bit 0 is released first.
REQ-011 Port: done output 1 high only in RUN.
REQ-012 Port: timeout_err output 1 sticky flag: lock timeout occurred since the last rst.
REQ-013 Port: retry_cnt output 4 count of lock timeouts since the last rst, saturating at 15.

Function
REQ-014 The FSM SHALL have exactly four states: HOLD, WAIT_LOCK, RELEASE, RUN.
REQ-015 HOLD: rst_out all ones; counter increments each cycle; after HOLD_CYCLES cycles in HOLD, go to WAIT_LOCK.
REQ-016 WAIT_LOCK: rst_out all ones; on a qualified lock, go to RELEASE next cycle; if the wait counter reaches LOCK_TIMEOUT first, set timeout_err, increment retry_cnt (saturating) and go to HOLD.
REQ-017 RELEASE: rst_out[i] SHALL deassert exactly STAGE_DELAY*(i+1) cycles after RELEASE entry; bits, once released, stay low until the next trigger.
REQ-018 When rst_out[NUM_STAGES-1] deasserts, the FSM SHALL enter RUN in that same cycle; done rises in that cycle.
REQ-019 RUN: rst_out all zeros, done=1; the FSM remains in RUN until a trigger occurs.
REQ-020 A trigger is soft_rst_req=1, or pll_locked=0 while in RELEASE or RUN; on a trigger the next state is HOLD, with rst_out all ones and done=0 on the next cycle.
REQ-021 soft_rst_req asserted in HOLD SHALL restart the hold counter; in WAIT_LOCK it SHALL return to HOLD.
REQ-022 A trigger and a timeout in the same cycle SHALL both go to HOLD; the timeout SHALL still be recorded.
REQ-023 All counters SHALL be sized from their parameters; none SHALL wrap during normal operation.

Reset
REQ-024 While rst=1: state=HOLD, counters=0, rst_out all ones, done=0, timeout_err=0, retry_cnt=0.
REQ-025 rst asserted mid-sequence from any state SHALL force the REQ-024 values on the next clock edge.
REQ-026 The first HOLD period SHALL begin on the first cycle after rst deasserts.

Configuration
REQ-027 Macro RESET_SEQ_LOCK_FILTER_EN defined: lock is qualified only after LOCK_FILTER consecutive cycles of pll_locked=1; the filter count clears on any low sample.
REQ-028 Macro RESET_SEQ_LOCK_FILTER_EN undefined: a single pll_locked=1 sample in WAIT_LOCK qualifies lock; no filter logic is instantiated.
REQ-029 Loss-of-lock detection in RELEASE and RUN SHALL be unfiltered in both builds.

Verification (NUM_STAGES=3, HOLD_CYCLES=16, STAGE_DELAY=8, LOCK_TIMEOUT=1000, LOCK_FILTER=4)
REQ-030 rst released, pll_locked held 1, filter off -> WAIT_LOCK at cycle 16; rst_out = 110, 100, 000 at 8, 16, 24 cycles after RELEASE entry; done=1 with the last release.
REQ-031 pll_locked held 0 -> timeout_err=1 and retry_cnt=1 after 16+1000 cycles; retry_cnt saturates at 15 after 15 or more timeouts.
REQ-032 In RUN, pll_locked drops to 0 for 1 cycle -> next cycle rst_out=111, done=0; full sequence repeats.
REQ-033 Filter on: pll_locked pattern 1,1,1,0,1,1,1,1 in WAIT_LOCK -> RELEASE entered only after the fourth consecutive 1.
REQ-034 soft_rst_req pulsed 4 cycles after RELEASE entry -> rst_out=111 the next cycle, HOLD lasts 16 cycles; rst pulsed mid-RELEASE -> timeout_err and retry_cnt clear.
